usb_fs_rx_phy: RTL and testbench

- Full-speed USB receive front end between the D+/D- pins and the USB controller core.
- Synchronizes D+/D- and recovers bit timing from line transitions.
- Detects SYNC, NRZI-decodes, removes stuffed bits and assembles bytes LSB-first.
- Detects EOP, bit-stuff/line errors and bus reset, and hands bytes to the controller through a valid-strobe interface.

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_fs_rx_phy_if.sv | 30 +++
 rtl/usb_rx_dpll.sv | 55 +++++
 rtl/usb_fs_rx_phy.sv | 259 +++++++++++++++++++++++++
 tb/tb_usb_fs_rx_phy.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared USB full-speed receive definitions: line states, rx FSM states and
// framing constants used by the PHY front end and its bit-timing recovery.
package usb_pkg;

    // Line states as seen on {d_p, d_n}.
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    // Minimum number of SYNC zeros before the closing 1 is accepted.
    localparam int unsigned SYNC_MIN_ZEROS = 4;
    // Longest run of decoded 1s before a stuffed 0 must follow.
    localparam int unsigned MAX_STUFF_RUN  = 6;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SYNC,
        RX_DATA,
        RX_EOP,
        RX_ERROR
    } rx_state_e;

    // NRZI: an unchanged symbol is a 1, a transition is a 0.
    function automatic logic nrzi_decode(input logic [1:0] sym, input logic [1:0] prev);
        return (sym == prev);
    endfunction

endpackage

// File: rtl/usb_fs_rx_phy_if.sv
// Controller-facing receive bus of the full-speed PHY. The PHY drives it
// through the master modport; the controller core observes it as slave.
interface usb_fs_rx_phy_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic       bus_reset;
    logic [1:0] line_state;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_active,
        output rx_error,
        output bus_reset,
        output line_state
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_active,
        input rx_error,
        input bus_reset,
        input line_state
    );

endinterface

// File: rtl/usb_rx_dpll.sv
// Bit-timing recovery: synchronizes D+/D-, realigns a phase counter on every
// line transition and strobes once per bit time in the middle of the bit.
module usb_rx_dpll
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_p,
    input  logic       d_n,
    output logic [1:0] line_state,
    output logic       sample_stb,
    output logic [1:0] sample_sym
);

    localparam int unsigned   PW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_MID = PW'(CLKS_PER_BIT / 2);

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [PW-1:0] phase_q, phase_d;

    // Next state: shift the synchronizer; restart the phase when line_state is about to change.
    always_comb begin
        sync1_d = {d_p, d_n};
        sync2_d = sync1_q;
        if (sync1_q != sync2_q) begin
            phase_d = '0;
        end else if (phase_q == PHASE_MAX) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // State registers; the synchronizer idles at J so reset does not look like a transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= LS_J;
            sync2_q <= LS_J;
            phase_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            phase_q <= phase_d;
        end
    end

    assign line_state = sync2_q;
    assign sample_stb = (phase_q == PHASE_MID);
    assign sample_sym = sync2_q;

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front end: SYNC detection, NRZI decode, bit
// unstuffing, LSB-first byte assembly, EOP / error / bus-reset detection.
module usb_fs_rx_phy
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned RESET_BITS   = 30,
    parameter int unsigned IDLE_BITS    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_p,
    input  logic            d_n,
    input  logic            vbus,
    usb_fs_rx_phy_if.master rx_if
);

    localparam int unsigned   SW          = $clog2(RESET_BITS + 1);
    localparam int unsigned   IW          = $clog2(IDLE_BITS + 1);
    localparam logic [SW-1:0] RESET_LIMIT = SW'(RESET_BITS);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_BITS - 1);
    localparam logic [2:0]    SYNC_MIN    = 3'(SYNC_MIN_ZEROS);
    localparam logic [2:0]    STUFF_RUN   = 3'(MAX_STUFF_RUN);

    logic       sample_stb;
    logic [1:0] sample_sym;
    logic [1:0] line_state;

    usb_rx_dpll #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_dpll (
        .clk       (clk),
        .rst       (rst),
        .d_p       (d_p),
        .d_n       (d_n),
        .line_state(line_state),
        .sample_stb(sample_stb),
        .sample_sym(sample_sym)
    );

    rx_state_e     state_q, state_d;
    logic [1:0]    prev_sym_q, prev_sym_d;
    logic [2:0]    zero_cnt_q, zero_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    eop_cnt_q, eop_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [SW-1:0] se0_cnt_q, se0_cnt_d;
    logic          bus_reset_q, bus_reset_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_active_q, rx_active_d;
    logic          rx_error_q, rx_error_d;

    logic bit_val;
    logic is_se0;
    logic is_se1;
    logic is_j;
    logic enter_err;

    // Receive FSM next state, evaluated once per sample strobe.
    always_comb begin
        state_d     = state_q;
        prev_sym_d  = prev_sym_q;
        zero_cnt_d  = zero_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        eop_cnt_d   = eop_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        se0_cnt_d   = se0_cnt_q;
        bus_reset_d = bus_reset_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_active_d = rx_active_q;
        rx_error_d  = 1'b0;
        enter_err   = 1'b0;

        bit_val = nrzi_decode(sample_sym, prev_sym_q);
        is_se0  = (sample_sym == LS_SE0);
        is_se1  = (sample_sym == LS_SE1);
        is_j    = (sample_sym == LS_J);

        if (sample_stb) begin
            // SE0 run length is tracked regardless of FSM state.
            if (is_se0) begin
                if (se0_cnt_q != RESET_LIMIT) begin
                    se0_cnt_d = se0_cnt_q + SW'(1);
                end
            end else begin
                se0_cnt_d = '0;
            end
            bus_reset_d = (se0_cnt_d >= RESET_LIMIT);

            case (state_q)
                RX_IDLE: begin
                    if (sample_sym == LS_K) begin
                        state_d    = RX_SYNC;
                        zero_cnt_d = 3'd1;
                        prev_sym_d = LS_K;
                    end else begin
                        prev_sym_d = LS_J;
                    end
                end
                RX_SYNC: begin
                    if (is_se0 || is_se1) begin
                        enter_err = 1'b1;
                    end else begin
                        prev_sym_d = sample_sym;
                        if (!bit_val) begin
                            if (zero_cnt_q != 3'd7) begin
                                zero_cnt_d = zero_cnt_q + 3'd1;
                            end
                        end else if (zero_cnt_q >= SYNC_MIN) begin
                            state_d     = RX_DATA;
                            rx_active_d = 1'b1;
                            ones_cnt_d  = '0;
                            bit_cnt_d   = '0;
                        end else begin
                            enter_err = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (is_se0) begin
                        // EOP must land on a byte boundary.
                        if (bit_cnt_q != 3'd0) begin
                            enter_err = 1'b1;
                        end else begin
                            state_d   = RX_EOP;
                            eop_cnt_d = 2'd1;
                        end
                    end else if (is_se1) begin
                        enter_err = 1'b1;
                    end else begin
                        prev_sym_d = sample_sym;
                        if (ones_cnt_q == STUFF_RUN) begin
                            // Stuffed bit: a 0 is dropped, a 1 breaks the stuffing rule.
                            if (bit_val) begin
                                enter_err = 1'b1;
                            end else begin
                                ones_cnt_d = '0;
                            end
                        end else begin
                            ones_cnt_d = bit_val ? ones_cnt_q + 3'd1 : 3'd0;
                            shift_d    = {bit_val, shift_q[7:1]};
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_d  = {bit_val, shift_q[7:1]};
                                rx_valid_d = 1'b1;
                            end
                        end
                    end
                end
                RX_EOP: begin
                    if (is_se0) begin
                        if (eop_cnt_q == 2'd3) begin
                            enter_err = 1'b1;
                        end else begin
                            eop_cnt_d = eop_cnt_q + 2'd1;
                        end
                    end else if (is_j) begin
                        state_d     = RX_IDLE;
                        rx_active_d = 1'b0;
                        prev_sym_d  = LS_J;
                    end else begin
                        enter_err = 1'b1;
                    end
                end
                RX_ERROR: begin
                    if (is_j) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d    = RX_IDLE;
                            idle_cnt_d = '0;
                            prev_sym_d = LS_J;
                        end else begin
                            idle_cnt_d = idle_cnt_q + IW'(1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase

            if (enter_err) begin
                state_d     = RX_ERROR;
                rx_error_d  = 1'b1;
                rx_active_d = 1'b0;
                idle_cnt_d  = '0;
            end

            // Bus reset overrides whatever the FSM decided, silently.
            if (bus_reset_d) begin
                state_d     = RX_IDLE;
                rx_active_d = 1'b0;
                rx_error_d  = 1'b0;
                rx_valid_d  = 1'b0;
                prev_sym_d  = LS_J;
                idle_cnt_d  = '0;
            end
        end

        // Without VBUS the receiver is parked; rx_data keeps its last byte.
        if (!vbus) begin
            state_d     = RX_IDLE;
            prev_sym_d  = LS_J;
            rx_active_d = 1'b0;
            rx_valid_d  = 1'b0;
            rx_error_d  = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            prev_sym_q  <= LS_J;
            zero_cnt_q  <= '0;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            eop_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            se0_cnt_q   <= '0;
            bus_reset_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_sym_q  <= prev_sym_d;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            eop_cnt_q   <= eop_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            bus_reset_q <= bus_reset_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx_if.rx_data    = rx_data_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.rx_active  = rx_active_q;
    assign rx_if.rx_error   = rx_error_q;
    assign rx_if.bus_reset  = bus_reset_q;
    assign rx_if.line_state = line_state;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Directed + randomized bench for usb_fs_rx_phy. A bench-side transmitter
// NRZI-encodes and bit-stuffs payload bytes; the expected result is simply
// the payload queue and the error count implied by each scenario.
module tb_usb_fs_rx_phy;
    import usb_pkg::*;

    logic clk;
    logic rst;
    logic d_p;
    logic d_n;
    logic vbus;

    usb_fs_rx_phy_if rx_if ();

    usb_fs_rx_phy #(
        .CLKS_PER_BIT(4),
        .RESET_BITS  (30),
        .IDLE_BITS   (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_p  (d_p),
        .d_n  (d_n),
        .vbus (vbus),
        .rx_if(rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         err_cnt = 0;
    int         both_cnt = 0;
    bit         active_seen = 1'b0;
    logic [1:0] lvl;
    int         ones;

    // Observe DUT strobes away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid) got_q.push_back(rx_if.rx_data);
            if (rx_if.rx_error) err_cnt++;
            if (rx_if.rx_valid && rx_if.rx_error) both_cnt++;
            if (rx_if.rx_active) active_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        err_cnt     = 0;
        both_cnt    = 0;
        active_seen = 1'b0;
    endtask

    task automatic drive(input logic [1:0] s, input int bits);
        {d_p, d_n} = s;
        repeat (bits * 4) @(negedge clk);
    endtask

    task automatic tx_bit(input bit b);
        if (!b) lvl = (lvl == LS_J) ? LS_K : LS_J;
        drive(lvl, 1);
    endtask

    task automatic tx_sync();
        lvl = LS_J;
        repeat (7) tx_bit(1'b0);
        tx_bit(1'b1);
        ones = 0;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx_bit(b[i]);
            if (b[i]) begin
                ones++;
                if (ones == 6) begin
                    tx_bit(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        exp_q.push_back(b);
    endtask

    task automatic tx_eop();
        drive(LS_SE0, 2);
        lvl = LS_J;
        drive(LS_J, 1);
    endtask

    task automatic check_packet(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        end
        check({tag, "_errors"}, err_cnt, 0);
        check({tag, "_overlap"}, both_cnt, 0);
        check({tag, "_active_end"}, rx_if.rx_active, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 3) == 0) b = 8'hFF;
        return b;
    endfunction

    initial begin
        logic [7:0] rb;
        int         nb;

        rst  = 1'b1;
        vbus = 1'b1;
        {d_p, d_n} = LS_J;
        lvl  = LS_J;
        ones = 0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_rx_data", rx_if.rx_data, 8'h00);
        check("rst_rx_valid", rx_if.rx_valid, 1'b0);
        check("rst_rx_active", rx_if.rx_active, 1'b0);
        check("rst_rx_error", rx_if.rx_error, 1'b0);
        check("rst_bus_reset", rx_if.bus_reset, 1'b0);
        check("rst_line_state", rx_if.line_state, LS_J);

        rst = 1'b0;
        clear_mon();
        drive(LS_J, 4);
        check("post_rst_valid", got_q.size(), 0);
        check("post_rst_error", err_cnt, 0);
        check("post_rst_active", active_seen, 1'b0);
        check("post_rst_line", rx_if.line_state, LS_J);

        // Good packet 0xA5.
        clear_mon();
        tx_sync();
        tx_byte(8'hA5);
        check("good_active_mid", rx_if.rx_active, 1'b1);
        tx_eop();
        drive(LS_J, 3);
        check_packet("good");
        check("good_rx_data", rx_if.rx_data, 8'hA5);
        check("good_active_seen", active_seen, 1'b1);

        // Stuffing across 0xFF, then 0x01.
        clear_mon();
        tx_sync();
        tx_byte(8'hFF);
        tx_byte(8'h01);
        tx_eop();
        drive(LS_J, 3);
        check_packet("stuff");

        // Random packets.
        for (int p = 0; p < 5; p++) begin
            clear_mon();
            nb = $urandom_range(1, 4);
            tx_sync();
            for (int k = 0; k < nb; k++) begin
                rb = rand_byte();
                tx_byte(rb);
            end
            tx_eop();
            drive(LS_J, 2);
            check_packet("rand");
        end

        // Stuff error: seven decoded 1s.
        clear_mon();
        tx_sync();
        repeat (7) tx_bit(1'b1);
        drive(LS_J, 10);
        check("stufferr_errors", err_cnt, 1);
        check("stufferr_valid", got_q.size(), 0);
        check("stufferr_active", rx_if.rx_active, 1'b0);
        check("stufferr_overlap", both_cnt, 0);
        clear_mon();
        tx_sync();
        rb = rand_byte();
        tx_byte(rb);
        tx_eop();
        drive(LS_J, 2);
        check_packet("after_stufferr");

        // Misaligned EOP after 5 data bits.
        clear_mon();
        tx_sync();
        rb = 8'($urandom);
        for (int i = 0; i < 5; i++) tx_bit(rb[i]);
        tx_eop();
        drive(LS_J, 10);
        check("misalign_errors", err_cnt, 1);
        check("misalign_valid", got_q.size(), 0);
        check("misalign_active", rx_if.rx_active, 1'b0);

        // Bus reset after 30 SE0 samples.
        clear_mon();
        drive(LS_SE0, 29);
        repeat (2) @(negedge clk);
        check("busrst_29", rx_if.bus_reset, 1'b0);
        repeat (4) @(negedge clk);
        check("busrst_30", rx_if.bus_reset, 1'b1);
        drive(LS_SE0, 5);
        check("busrst_hold", rx_if.bus_reset, 1'b1);
        check("busrst_errors", err_cnt, 0);
        check("busrst_active", active_seen, 1'b0);
        {d_p, d_n} = LS_J;
        repeat (6) @(negedge clk);
        check("busrst_release", rx_if.bus_reset, 1'b0);
        drive(LS_J, 3);

        // VBUS absent: receiver ignores a full good packet.
        vbus = 1'b0;
        clear_mon();
        tx_sync();
        rb = rand_byte();
        tx_byte(rb);
        tx_eop();
        drive(LS_J, 2);
        check("novbus_active", active_seen, 1'b0);
        check("novbus_valid", got_q.size(), 0);
        check("novbus_errors", err_cnt, 0);
        {d_p, d_n} = LS_K;
        repeat (3) @(negedge clk);
        check("novbus_line_k", rx_if.line_state, LS_K);
        drive(LS_J, 2);
        vbus = 1'b1;
        drive(LS_J, 2);

        // Asynchronous reset mid-packet.
        clear_mon();
        tx_sync();
        tx_bit(1'b1);
        tx_bit(1'b0);
        check("arst_active_before", rx_if.rx_active, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_active", rx_if.rx_active, 1'b0);
        check("arst_line", rx_if.line_state, LS_J);
        @(negedge clk);
        {d_p, d_n} = LS_J;
        lvl = LS_J;
        rst = 1'b0;
        drive(LS_J, 4);
        clear_mon();
        tx_sync();
        rb = rand_byte();
        tx_byte(rb);
        tx_eop();
        drive(LS_J, 2);
        check_packet("after_arst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
